// File: rtl/taylor_axil_pkg.sv
// rtl/taylor_axil_pkg.sv - shared types and helpers for the Taylor AXI4-Lite register file
package taylor_axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   // Number of byte-offset address bits below the register index
   function automatic int addr_lsb(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/taylor_axil_strb_merge.sv
// rtl/taylor_axil_strb_merge.sv - byte-strobe merge of new write data onto an old register word
module taylor_axil_strb_merge
   import taylor_axil_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_word,
   input  logic [DATA_W-1:0]   new_word,
   input  logic [DATA_W/8-1:0] strb,
   output logic [DATA_W-1:0]   merged
);

   // Each enabled byte lane takes the new data, disabled lanes keep the old value
   always_comb begin
      merged = old_word;
      for (int b = 0; b < DATA_W / 8; b++) begin
         if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
   end

endmodule

// File: rtl/taylor_axil_regfile.sv
// rtl/taylor_axil_regfile.sv - parametrised AXI4-Lite slave register file for the Taylor compute core
module taylor_axil_regfile
   import taylor_axil_pkg::*;
#(
   parameter int                         DATA_W    = 32,
   parameter int                         NUM_REGS  = 8,
   parameter int                         ADDR_W    = 8,
   parameter logic [NUM_REGS-1:0]        RO_MASK   = 8'b1000_0000,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                         s_axi_aclk,
   input  logic                         s_axi_areset,
   input  logic [ADDR_W-1:0]            s_axi_awaddr,
   input  logic [2:0]                   s_axi_awprot,
   input  logic                         s_axi_awvalid,
   output logic                         s_axi_awready,
   input  logic [DATA_W-1:0]            s_axi_wdata,
   input  logic [DATA_W/8-1:0]          s_axi_wstrb,
   input  logic                         s_axi_wvalid,
   output logic                         s_axi_wready,
   output logic [1:0]                   s_axi_bresp,
   output logic                         s_axi_bvalid,
   input  logic                         s_axi_bready,
   input  logic [ADDR_W-1:0]            s_axi_araddr,
   input  logic [2:0]                   s_axi_arprot,
   input  logic                         s_axi_arvalid,
   output logic                         s_axi_arready,
   output logic [DATA_W-1:0]            s_axi_rdata,
   output logic [1:0]                   s_axi_rresp,
   output logic                         s_axi_rvalid,
   input  logic                         s_axi_rready,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          reg_wr_pulse,
   input  logic [NUM_REGS*DATA_W-1:0]   ro_d
);

   localparam int ADDR_LSB = addr_lsb(DATA_W);
   localparam int STRB_W   = DATA_W / 8;
   localparam int IDX_W    = ADDR_W - ADDR_LSB;

   wr_state_t           wr_state;
   rd_state_t           rd_state;
   logic [DATA_W-1:0]   regs [NUM_REGS];

   // AW and W may arrive separately; whichever comes first is parked here
   logic                aw_held;
   logic                w_held;
   logic [ADDR_W-1:0]   awaddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;

   logic                aw_hs;
   logic                w_hs;
   logic                ar_hs;
   logic                commit;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [STRB_W-1:0]   wr_strb;
   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    rd_idx;
   logic                wr_hit;
   logic                wr_ro;
   logic                wr_legal;
   logic [NUM_REGS-1:0] wr_onehot;
   logic [DATA_W-1:0]   wr_old;
   logic [DATA_W-1:0]   wr_merged;
   logic                rd_hit;
   logic [DATA_W-1:0]   rd_word;
   logic                unused_ok;

   assign aw_hs   = s_axi_awvalid & s_axi_awready;
   assign w_hs    = s_axi_wvalid & s_axi_wready;
   assign ar_hs   = s_axi_arvalid & s_axi_arready;
   assign wr_addr = aw_held ? awaddr_q : s_axi_awaddr;
   assign wr_data = w_held ? wdata_q : s_axi_wdata;
   assign wr_strb = w_held ? wstrb_q : s_axi_wstrb;
   assign wr_idx  = wr_addr[ADDR_W-1:ADDR_LSB];
   assign rd_idx  = s_axi_araddr[ADDR_W-1:ADDR_LSB];
   assign commit  = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
   assign wr_legal = wr_hit && !wr_ro;

   // Protection bits and sub-word address bits carry no meaning here
   assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                        wr_addr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

   // Write index decode: range hit, read-only flag, one-hot target and current contents
   always_comb begin
      wr_hit    = 1'b0;
      wr_ro     = 1'b0;
      wr_onehot = '0;
      wr_old    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_idx == IDX_W'(i)) begin
            wr_hit       = 1'b1;
            wr_ro        = RO_MASK[i];
            wr_onehot[i] = 1'b1;
            wr_old       = regs[i];
         end
      end
   end

   // Read index decode: RO slots return live status, out-of-range returns zero
   always_comb begin
      rd_hit  = 1'b0;
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_hit  = 1'b1;
            rd_word = RO_MASK[i] ? ro_d[i*DATA_W +: DATA_W] : regs[i];
         end
      end
   end

   taylor_axil_strb_merge #(
      .DATA_W (DATA_W)
   ) u_strb_merge (
      .old_word (wr_old),
      .new_word (wr_data),
      .strb     (wr_strb),
      .merged   (wr_merged)
   );

   // Register storage: updated only by a legal commit
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end else if (commit && wr_legal) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_onehot[i]) regs[i] <= wr_merged;
         end
      end
   end

   // Write channel FSM: collect AW and W, commit, then hold B until accepted
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         wr_state      <= W_IDLE;
         s_axi_awready <= 1'b1;
         s_axi_wready  <= 1'b1;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= OKAY;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         reg_wr_pulse  <= '0;
      end else begin
         reg_wr_pulse <= '0;
         case (wr_state)
            W_IDLE: begin
               if (commit) begin
                  s_axi_bvalid  <= 1'b1;
                  s_axi_bresp   <= wr_legal ? OKAY : SLVERR;
                  reg_wr_pulse  <= wr_legal ? wr_onehot : '0;
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b0;
                  aw_held       <= 1'b0;
                  w_held        <= 1'b0;
                  wr_state      <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_held       <= 1'b1;
                     awaddr_q      <= s_axi_awaddr;
                     s_axi_awready <= 1'b0;
                  end
                  if (w_hs) begin
                     w_held       <= 1'b1;
                     wdata_q      <= s_axi_wdata;
                     wstrb_q      <= s_axi_wstrb;
                     s_axi_wready <= 1'b0;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  s_axi_wready  <= 1'b1;
                  wr_state      <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // Read channel FSM: register data at the AR handshake, hold R until accepted
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         rd_state      <= R_IDLE;
         s_axi_arready <= 1'b1;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  s_axi_rdata   <= rd_word;
                  s_axi_rresp   <= rd_hit ? OKAY : SLVERR;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_arready <= 1'b0;
                  rd_state      <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  s_axi_rvalid  <= 1'b0;
                  s_axi_arready <= 1'b1;
                  rd_state      <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // RW contents exported to the core; RO slots read as zero
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
      assign reg_q[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs[g];
   end

endmodule
